// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Round-robin arbiter sharing one single-ported memory bus between N
// requesters using a level-request / one-cycle-acknowledge handshake.
// A grant-lock hint lets the last owner keep the bus for back-to-back
// transfers. Every transfer takes IDLE -> BUSY -> RESP -> IDLE, so a
// zero-wait memory gives one transfer every 3 cycles.
//
// Optional build macro: MEM_PORT_ARB_TIMEOUT_EN
//   defined   : a stall counter aborts a BUSY transfer after TIMEOUT_CYC
//               cycles without m_ack_i and reports it on err_o.
//   undefined : BUSY waits for m_ack_i indefinitely; err_o is tied low.

module mem_port_arbiter #(
    parameter int N           = 3,
    parameter int AW          = 32,
    parameter int DW          = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    req_i,
    input  logic [N-1:0]    lock_i,
    input  logic [N-1:0]    we_i,
    input  logic [N*AW-1:0] addr_i,
    input  logic [N*DW-1:0] wdat_i,
    output logic [N-1:0]    ack_o,
    output logic            err_o,
    output logic [DW-1:0]   rdat_o,
    output logic [N-1:0]    grant_o,
    output logic            m_stb_o,
    output logic            m_we_o,
    output logic [AW-1:0]   m_addr_o,
    output logic [DW-1:0]   m_wdat_o,
    input  logic            m_ack_i,
    input  logic [DW-1:0]   m_rdat_i
);

    // Index width for requester numbers (N is at least 2).
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State registers and their next values
    // ------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_next;
    logic [PW-1:0]   r_ptr;          // last granted requester
    logic [PW-1:0]   w_ptr_next;
    logic            r_lock;         // lock hint captured at last completion
    logic            w_lock_next;
    logic [PW-1:0]   r_win;          // owner of the transfer in flight
    logic [PW-1:0]   w_win_next;
    logic [N-1:0]    r_grant;
    logic [N-1:0]    w_grant_next;
    logic [N-1:0]    r_ack;
    logic [N-1:0]    w_ack_next;
    logic [DW-1:0]   r_rdat;
    logic [DW-1:0]   w_rdat_next;
    logic            r_stb;
    logic            w_stb_next;
    logic            r_we;
    logic            w_we_next;
    logic [AW-1:0]   r_addr;
    logic [AW-1:0]   w_addr_next;
    logic [DW-1:0]   r_wdat;
    logic [DW-1:0]   w_wdat_next;

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CW-1:0]   r_tcnt;         // BUSY cycles seen without m_ack_i
    logic [CW-1:0]   w_tcnt_next;
    logic            r_err;
    logic            w_err_next;
`else
    // Stall limit only matters in the timeout build; this empty block just
    // keeps the parameter referenced so both builds share one interface.
    if (TIMEOUT_CYC < 1) begin : g_timeout_unused
    end
`endif

    // ------------------------------------------------------------------
    // Per-requester command fields and round-robin candidate order
    // ------------------------------------------------------------------
    logic [AW-1:0]   w_addr  [N];
    logic [DW-1:0]   w_wdat  [N];
    logic [PW:0]     w_sum   [N];    // ptr + offset before wrapping
    logic [PW-1:0]   w_cand  [N];    // candidate index at search offset gi+1
    logic [N-1:0]    w_req_rot;      // req_i seen in search order
    logic [PW-1:0]   w_rr_idx;
    logic [PW-1:0]   w_win_idx;
    logic [N-1:0]    w_win_oh;

    for (genvar gi = 0; gi < N; gi++) begin : g_req
        assign w_addr[gi]    = addr_i[gi*AW +: AW];
        assign w_wdat[gi]    = wdat_i[gi*DW +: DW];
        // Search order starts one past the last owner and wraps modulo N.
        assign w_sum[gi]     = {1'b0, r_ptr} + (PW+1)'(gi + 1);
        assign w_cand[gi]    = (w_sum[gi] >= (PW+1)'(N))
                             ? PW'(w_sum[gi] - (PW+1)'(N))
                             : w_sum[gi][PW-1:0];
        assign w_req_rot[gi] = req_i[w_cand[gi]];
        assign w_win_oh[gi]  = (w_win_idx == PW'(gi));
    end

    // Lowest search offset with a pending request wins the rotation.
    always_comb begin
        w_rr_idx = r_ptr;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_rr_idx = w_cand[i];
            end
        end
    end

    // A locked owner that is still requesting keeps the bus.
    assign w_win_idx = (r_lock && req_i[r_ptr]) ? r_ptr : w_rr_idx;

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    // Computes every register's next value; all default to holding.
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_lock_next  = r_lock;
        w_win_next   = r_win;
        w_grant_next = r_grant;
        w_ack_next   = r_ack;
        w_rdat_next  = r_rdat;
        w_stb_next   = r_stb;
        w_we_next    = r_we;
        w_addr_next  = r_addr;
        w_wdat_next  = r_wdat;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
        w_tcnt_next  = r_tcnt;
        w_err_next   = r_err;
`endif
        case (r_state)
            ST_IDLE: begin
                if (|req_i) begin
                    w_win_next   = w_win_idx;
                    w_grant_next = w_win_oh;
                    w_stb_next   = 1'b1;
                    w_we_next    = we_i[w_win_idx];
                    w_addr_next  = w_addr[w_win_idx];
                    w_wdat_next  = w_wdat[w_win_idx];
`ifdef MEM_PORT_ARB_TIMEOUT_EN
                    w_tcnt_next  = '0;
`endif
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A real completion takes priority over a same-cycle timeout.
                if (m_ack_i) begin
                    w_rdat_next  = m_rdat_i;
                    w_stb_next   = 1'b0;
                    w_we_next    = 1'b0;
                    w_ack_next   = r_grant;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
                    w_err_next   = 1'b0;
`endif
                    w_state_next = ST_RESP;
                end
`ifdef MEM_PORT_ARB_TIMEOUT_EN
                else if (r_tcnt == CW'(TIMEOUT_CYC - 1)) begin
                    w_rdat_next  = '0;
                    w_stb_next   = 1'b0;
                    w_we_next    = 1'b0;
                    w_ack_next   = r_grant;
                    w_err_next   = 1'b1;
                    w_state_next = ST_RESP;
                end else begin
                    w_tcnt_next  = r_tcnt + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                w_ack_next   = '0;
                w_grant_next = '0;
                w_ptr_next   = r_win;
                w_lock_next  = lock_i[r_win];
`ifdef MEM_PORT_ARB_TIMEOUT_EN
                w_err_next   = 1'b0;
`endif
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Register update; reset abandons any transfer without acknowledging it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_ptr   <= PW'(N - 1);
            r_lock  <= 1'b0;
            r_win   <= '0;
            r_grant <= '0;
            r_ack   <= '0;
            r_rdat  <= '0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdat  <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_lock  <= w_lock_next;
            r_win   <= w_win_next;
            r_grant <= w_grant_next;
            r_ack   <= w_ack_next;
            r_rdat  <= w_rdat_next;
            r_stb   <= w_stb_next;
            r_we    <= w_we_next;
            r_addr  <= w_addr_next;
            r_wdat  <= w_wdat_next;
        end
    end

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    // Stall counter and abort flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            r_tcnt <= w_tcnt_next;
            r_err  <= w_err_next;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    assign ack_o    = r_ack;
    assign rdat_o   = r_rdat;
    assign grant_o  = r_grant;
    assign m_stb_o  = r_stb;
    assign m_we_o   = r_we;
    assign m_addr_o = r_addr;
    assign m_wdat_o = r_wdat;

endmodule
